// File: rtl/spi_regbank_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_regbank_pkg : shared types and helpers for the SPI register bank
// Rev 1.0
// ---------------------------------------------------------------------------
package spi_regbank_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    HOLD = 3'd4
  } state_e;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_sync : 2-FF synchroniser with edge detection against a third flop
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_regbank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_regbank : SPI mode-0 target exposing NUM_REGS read/write registers
// Rev 1.0
// ---------------------------------------------------------------------------
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int NUM_REGS = 5,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_stb
);

  localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int SH_W  = MAX_W + 1;
  localparam int CNT_W = cnt_w(MAX_W);
  localparam int AW1   = ADDR_W + 1;

  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic copi_lvl, copi_rise_unused, copi_fall_unused;
  logic ncs_lvl, ncs_rise, ncs_fall_unused;

  spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync #(.RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d(copi),
    .level(copi_lvl), .rise(copi_rise_unused), .fall(copi_fall_unused)
  );
  // ncs idles high so a chip select held low across reset still opens a frame
  spi_sync #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs),
    .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall_unused)
  );

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [SH_W-1:0]     shin_q, shin_d;
  logic [DATA_W-1:0]   shout_q, shout_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rw_q, rw_d;
  logic                addr_ok_q, addr_ok_d;
  logic                overrun_q, overrun_d;
  logic                load_pend_q, load_pend_d;
  logic                cipo_q, cipo_d;
  logic                cipo_oe_q, cipo_oe_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_stb_q, wr_stb_d;

  logic [SH_W-1:0]     shin_next;
  logic [ADDR_W-1:0]   addr_next;
  logic [DATA_W-1:0]   rd_data;
  logic                commit;

  assign shin_next = {shin_q[SH_W-2:0], copi_lvl};
  assign addr_next = shin_next[ADDR_W-1:0];
  assign commit    = ncs_rise && (state_q == HOLD) && !overrun_q && rw_q && addr_ok_q;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (addr_ok_q && (addr_q == ADDR_W'(i))) rd_data = regs_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    out_cnt_d   = out_cnt_q;
    shin_d      = shin_q;
    shout_d     = shout_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    addr_ok_d   = addr_ok_q;
    overrun_d   = overrun_q;
    load_pend_d = load_pend_q;
    cipo_d      = cipo_q;
    cipo_oe_d   = ~ncs_lvl;
    regs_d      = regs_q;
    wr_stb_d    = '0;

    // A chip-select release outranks any sclk edge seen in the same cycle
    if (ncs_rise) begin
      state_d     = IDLE;
      load_pend_d = 1'b0;
      out_cnt_d   = '0;
      cipo_d      = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit && (addr_q == ADDR_W'(i))) begin
          regs_d[i]   = shin_q[DATA_W-1:0];
          wr_stb_d[i] = 1'b1;
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (!ncs_lvl) begin
            bit_cnt_d   = '0;
            shin_d      = '0;
            rw_d        = 1'b0;
            addr_ok_d   = 1'b0;
            overrun_d   = 1'b0;
            load_pend_d = 1'b0;
            out_cnt_d   = '0;
            cipo_d      = 1'b0;
            state_d     = CMD;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            rw_d    = copi_lvl;
            state_d = ADDR;
          end
        end
        ADDR: begin
          if (sclk_rise) begin
            shin_d    = shin_next;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(ADDR_W - 1)) begin
              addr_d      = addr_next;
              addr_ok_d   = ({1'b0, addr_next} < AW1'(NUM_REGS));
              bit_cnt_d   = '0;
              load_pend_d = 1'b1;
              state_d     = DATA;
            end
          end
        end
        DATA: begin
          if (sclk_rise) begin
            shin_d    = shin_next;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = HOLD;
          end
        end
        HOLD: begin
          if (sclk_rise) overrun_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      // Read-out runs alongside the receive path, starting on the first fall after the address
      if (sclk_fall && (state_q != IDLE)) begin
        if (load_pend_q) begin
          cipo_d      = rd_data[DATA_W-1];
          shout_d     = rd_data << 1;
          out_cnt_d   = CNT_W'(DATA_W - 1);
          load_pend_d = 1'b0;
        end else if (out_cnt_q != '0) begin
          cipo_d    = shout_q[DATA_W-1];
          shout_d   = shout_q << 1;
          out_cnt_d = out_cnt_q - CNT_W'(1);
        end else begin
          cipo_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      out_cnt_q   <= '0;
      shin_q      <= '0;
      shout_q     <= '0;
      addr_q      <= '0;
      rw_q        <= 1'b0;
      addr_ok_q   <= 1'b0;
      overrun_q   <= 1'b0;
      load_pend_q <= 1'b0;
      cipo_q      <= 1'b0;
      cipo_oe_q   <= 1'b0;
      wr_stb_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      out_cnt_q   <= out_cnt_d;
      shin_q      <= shin_d;
      shout_q     <= shout_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      addr_ok_q   <= addr_ok_d;
      overrun_q   <= overrun_d;
      load_pend_q <= load_pend_d;
      cipo_q      <= cipo_d;
      cipo_oe_q   <= cipo_oe_d;
      wr_stb_q    <= wr_stb_d;
      regs_q      <= regs_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      assign reg_q[gi*DATA_W +: DATA_W] = regs_q[gi];
    end
  endgenerate

  assign cipo    = cipo_q;
  assign cipo_oe = cipo_oe_q;
  assign wr_stb  = wr_stb_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_regbank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_regbank : directed scoreboard bench for two spi_regbank configurations
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_regbank;

  localparam int HALF = 50;

  logic         clk = 1'b0;
  logic         rst_n, sclk, copi, ncs0, ncs1;
  logic         cipo0, oe0, cipo1, oe1;
  logic [39:0]  rq0;
  logic [4:0]   stb0;
  logic [255:0] rq1;
  logic [15:0]  stb1;

  int n_cmp = 0;
  int n_mis = 0;

  logic [7:0]  m0 [5];
  logic [15:0] m1 [16];
  logic [15:0] exp_rd[$];
  logic [15:0] exp_stb0[$], exp_stb1[$];
  logic [15:0] obs0[$], obs1[$];

  always #5 clk = ~clk;

  spi_regbank u_dut0 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs0),
    .cipo(cipo0), .cipo_oe(oe0), .reg_q(rq0), .wr_stb(stb0)
  );

  spi_regbank #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs1),
    .cipo(cipo1), .cipo_oe(oe1), .reg_q(rq1), .wr_stb(stb1)
  );

  always @(negedge clk) begin
    if (stb0 != '0) obs0.push_back(16'(stb0));
    if (stb1 != '0) obs1.push_back(stb1);
  end

  task automatic check(input string tag, input logic [255:0] o, input logic [255:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [255:0] vec(input int d);
    logic [255:0] v;
    v = '0;
    if (d == 0) for (int i = 0; i < 5; i++)  v[i*8 +: 8]   = m0[i];
    else        for (int i = 0; i < 16; i++) v[i*16 +: 16] = m1[i];
    return v;
  endfunction

  function automatic logic get_cipo(input int d);
    return (d == 0) ? cipo0 : cipo1;
  endfunction

  function automatic logic get_oe(input int d);
    return (d == 0) ? oe0 : oe1;
  endfunction

  task automatic set_ncs(input int d, input logic v);
    if (d == 0) ncs0 = v;
    else        ncs1 = v;
  endtask

  function automatic logic [63:0] build(input int d, input bit rw, input int addr, input int data);
    int aw, dw, flen;
    aw   = (d != 0) ? 4 : 7;
    dw   = (d != 0) ? 16 : 8;
    flen = 1 + aw + dw;
    return (64'(rw) << (flen - 1)) | (64'(addr) << dw) | 64'(data);
  endfunction

  task automatic frame(input int d, input bit rw, input int addr, input int data,
                       input int nbits, input string tag, output logic [15:0] rd);
    int aw, dw, flen;
    logic [63:0] fr;
    aw   = (d != 0) ? 4 : 7;
    dw   = (d != 0) ? 16 : 8;
    flen = 1 + aw + dw;
    fr   = build(d, rw, addr, data);
    rd   = '0;
    set_ncs(d, 1'b0);
    #100;
    check({tag, "_oe_hi"}, 256'(get_oe(d)), 256'(1'b1));
    for (int i = 0; i < nbits; i++) begin
      copi = (i < flen) ? fr[flen-1-i] : 1'b0;
      #HALF;
      if (i >= 1 + aw && i < 1 + aw + dw) rd = {rd[14:0], get_cipo(d)};
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    #HALF;
    set_ncs(d, 1'b1);
    #200;
  endtask

  task automatic check_stb(input int d, input string tag);
    logic [15:0] e, o;
    if (d == 0) begin
      while (exp_stb0.size() > 0) begin
        e = exp_stb0.pop_front();
        o = '0;
        if (obs0.size() > 0) o = obs0.pop_front();
        check({tag, "_stb"}, 256'(o), 256'(e));
      end
      check({tag, "_stb_extra"}, 256'(obs0.size()), 256'(0));
      obs0.delete();
    end else begin
      while (exp_stb1.size() > 0) begin
        e = exp_stb1.pop_front();
        o = '0;
        if (obs1.size() > 0) o = obs1.pop_front();
        check({tag, "_stb"}, 256'(o), 256'(e));
      end
      check({tag, "_stb_extra"}, 256'(obs1.size()), 256'(0));
      obs1.delete();
    end
  endtask

  task automatic xfer(input int d, input bit rw, input int addr, input int data,
                      input int nbits, input bit chk_rd, input string tag);
    int nr, flen;
    logic [15:0] rd, e;
    nr   = (d != 0) ? 16 : 5;
    flen = (d != 0) ? 21 : 16;
    e    = '0;
    if (addr < nr) e = (d != 0) ? m1[addr] : 16'(m0[addr]);
    exp_rd.push_back(e);
    if (rw && nbits == flen && addr < nr) begin
      if (d == 0) begin
        exp_stb0.push_back(16'(1) << addr);
        m0[addr] = 8'(data);
      end else begin
        exp_stb1.push_back(16'(1) << addr);
        m1[addr] = 16'(data);
      end
    end
    frame(d, rw, addr, data, nbits, tag, rd);
    e = exp_rd.pop_front();
    if (chk_rd) check({tag, "_rd"}, 256'(rd), 256'(e));
    check_stb(d, tag);
    check({tag, "_regs"}, (d == 0) ? 256'(rq0) : rq1, vec(d));
    check({tag, "_oe_lo"}, 256'(get_oe(d)), 256'(1'b0));
  endtask

  initial begin
    logic [63:0] fr;
    for (int i = 0; i < 5; i++)  m0[i] = '0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
    rst_n = 1'b0;
    sclk  = 1'b0;
    copi  = 1'b0;
    ncs0  = 1'b1;
    ncs1  = 1'b1;
    #23;
    check("rst_regs0", 256'(rq0), 256'(0));
    check("rst_stb0",  256'(stb0), 256'(0));
    check("rst_cipo0", 256'(cipo0), 256'(0));
    check("rst_oe0",   256'(oe0), 256'(0));
    check("rst_regs1", rq1, 256'(0));
    check("rst_stb1",  256'(stb1), 256'(0));
    rst_n = 1'b1;
    #60;
    check("idle_oe0", 256'(oe0), 256'(0));

    xfer(0, 1'b1, 2, 'hA5, 16, 1'b1, "wr_a5");
    xfer(0, 1'b1, 4, 'h3C, 16, 1'b1, "wr_3c");
    xfer(0, 1'b0, 4, 0,    16, 1'b1, "rd_3c");
    xfer(0, 1'b1, 4, 'h77, 16, 1'b1, "rbw_77");
    xfer(0, 1'b1, 5, 'hFF, 16, 1'b1, "wr_oor");
    xfer(0, 1'b0, 5, 0,    16, 1'b1, "rd_oor");
    xfer(0, 1'b1, 0, 'h11, 10, 1'b0, "short");
    xfer(0, 1'b1, 0, 'h11, 17, 1'b1, "long");

    // reset pulsed six bits into a write of address 1
    fr   = build(0, 1'b1, 1, 'h5A);
    ncs0 = 1'b0;
    #100;
    for (int i = 0; i < 6; i++) begin
      copi = fr[15-i];
      #HALF;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_regs0", 256'(rq0), 256'(0));
    check("midrst_stb0",  256'(stb0), 256'(0));
    check("midrst_cipo0", 256'(cipo0), 256'(0));
    for (int i = 0; i < 5; i++)  m0[i] = '0;
    for (int i = 0; i < 16; i++) m1[i] = '0;
    obs0.delete();
    obs1.delete();
    #19;
    rst_n = 1'b1;
    #100;
    check("midrst_oe_hi", 256'(oe0), 256'(1'b1));
    ncs0 = 1'b1;
    #200;
    check_stb(0, "midrst_end");
    check("midrst_end_regs", 256'(rq0), vec(0));

    xfer(0, 1'b1, 1, 'h5A, 16, 1'b1, "wr_5a");
    xfer(0, 1'b0, 1, 0,    16, 1'b1, "rd_5a");

    xfer(1, 1'b1, 15, 'hBEEF, 21, 1'b1, "w16_beef");
    check("w16_slice", 256'(rq1[255:240]), 256'(16'hBEEF));
    xfer(1, 1'b0, 15, 0, 21, 1'b1, "r16_beef");
    check("dut0_untouched", 256'(rq0), vec(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
